// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants and types for the unified instruction/data memory arbiter.
// Holds the RISC-V load/store funct3 codes, the owner encoding and the pending-slot record.
package unified_mem_arbiter_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // Everything needed to complete an access one cycle after it was issued.
  typedef struct packed {
    logic [1:0] owner;
    logic [1:0] addr_lo;
    logic [2:0] funct3;
    logic       we;
    logic       misalign;
  } pending_t;

endpackage

// File: rtl/unified_mem_arbiter_load_store_align.sv
// Combinational lane steering for stores and lane extraction/extension for loads.
// Flags funct3 values that are illegal for the access direction or misaligned addresses.
module load_store_align
  import unified_mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    misalign  = 1'b0;
    byte_en   = 4'b0000;
    wdata_out = 32'h0;
    rdata_out = 32'h0;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr;
        wdata_out = {4{wdata[7:0]}};
        rdata_out = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        if (addr[0]) begin
          misalign = 1'b1;
        end else begin
          byte_en   = 4'b0011 << addr;
          wdata_out = {2{wdata[15:0]}};
          rdata_out = {{16{half_sel[15]}}, half_sel};
        end
      end
      F3_W: begin
        if (addr != 2'b00) begin
          misalign = 1'b1;
        end else begin
          byte_en   = 4'b1111;
          wdata_out = wdata;
          rdata_out = rdata;
        end
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        if (we) misalign = 1'b1;
        else    rdata_out = {24'h0, byte_sel};
      end
      F3_HU: begin
        if (we || addr[0]) misalign = 1'b1;
        else               rdata_out = {16'h0, half_sel};
      end
      default: misalign = 1'b1;
    endcase

    if (misalign || !we) begin
      byte_en   = 4'b0000;
      wdata_out = 32'h0;
    end
    if (misalign || we) begin
      rdata_out = 32'h0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and the load/store port.
// Grants at most one access per cycle (data first), acknowledging each one cycle later.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_misalign,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  pending_t    pend_q, pend_d;
  logic        if_elig, d_elig, if_mis;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, st_rdata_unused;
  logic        st_misalign;
  logic [3:0]  ld_be_unused;
  logic [31:0] ld_wdata_unused, ld_rdata;
  logic        ld_misalign_unused;

  load_store_align u_store_align (
    .funct3    (d_funct3),
    .addr      (d_addr[1:0]),
    .we        (d_we),
    .wdata     (d_wdata),
    .rdata     (32'h0),
    .byte_en   (st_be),
    .wdata_out (st_wdata),
    .rdata_out (st_rdata_unused),
    .misalign  (st_misalign)
  );

  // Second instance works on the registered request to extract returning load data.
  load_store_align u_load_align (
    .funct3    (pend_q.funct3),
    .addr      (pend_q.addr_lo),
    .we        (pend_q.we),
    .wdata     (32'h0),
    .rdata     (mem_rdata),
    .byte_en   (ld_be_unused),
    .wdata_out (ld_wdata_unused),
    .rdata_out (ld_rdata),
    .misalign  (ld_misalign_unused)
  );

  always_comb begin
    if_elig   = if_req && (pend_q.owner != OWN_IF);
    d_elig    = d_req  && (pend_q.owner != OWN_D);
    if_mis    = (if_addr[1:0] != 2'b00);
    pend_d    = '0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    // Reset gates the issue path so outputs stay quiet while requests are still held.
    if (rst && d_elig) begin
      pend_d.owner    = OWN_D;
      pend_d.addr_lo  = d_addr[1:0];
      pend_d.funct3   = d_funct3;
      pend_d.we       = d_we;
      pend_d.misalign = st_misalign;
      if (!st_misalign) begin
        mem_en    = 1'b1;
        mem_we    = st_be;
        mem_addr  = d_addr[MEM_AW+1:2];
        mem_wdata = st_wdata;
      end
    end else if (rst && if_elig) begin
      pend_d.owner    = OWN_IF;
      pend_d.addr_lo  = if_addr[1:0];
      pend_d.funct3   = F3_W;
      pend_d.we       = 1'b0;
      pend_d.misalign = if_mis;
      if (!if_mis) begin
        mem_en   = 1'b1;
        mem_addr = if_addr[MEM_AW+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  always_comb begin
    if_ack      = (pend_q.owner == OWN_IF);
    if_misalign = if_ack && pend_q.misalign;
    if_rdata    = (if_ack && !pend_q.misalign) ? mem_rdata : 32'h0;
    d_ack       = (pend_q.owner == OWN_D);
    d_misalign  = d_ack && pend_q.misalign;
    d_rdata     = (d_ack && !pend_q.misalign && !pend_q.we) ? ld_rdata : 32'h0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural synchronous-read memory.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_misalign;
  logic        d_req, d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int tests = 0;
  int fails = 0;

  logic        is_en;
  logic [3:0]  is_we;
  logic [9:0]  is_addr;
  logic [31:0] is_wdata;
  logic        ak_ack, ak_mis, ak_en;
  logic [31:0] ak_rdata;

  unified_mem_arbiter #(.MEM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_rdata    (if_rdata),
    .if_misalign (if_misalign),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_funct3    (d_funct3),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .d_misalign  (d_misalign),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete data access, capturing issue-cycle and ack-cycle observations.
  task automatic d_access(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    @(negedge clk);
    is_en = mem_en; is_we = mem_we; is_addr = mem_addr; is_wdata = mem_wdata;
    next_cycle();
    @(negedge clk);
    ak_ack = d_ack; ak_rdata = d_rdata; ak_mis = d_misalign; ak_en = mem_en;
    next_cycle();
    d_req = 1'b0;
  endtask

  task automatic f_access(input logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    is_en = mem_en; is_we = mem_we; is_addr = mem_addr; is_wdata = mem_wdata;
    next_cycle();
    @(negedge clk);
    ak_ack = if_ack; ak_rdata = if_rdata; ak_mis = if_misalign; ak_en = mem_en;
    next_cycle();
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h23; d_wdata = 32'hAB;
    @(posedge clk);
    @(negedge clk);
    tests++; if (mem_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); end
    tests++; if (mem_we !== 4'b0) begin fails++; $display("[TB] FAIL reset_mem_we: got %b expected 0000", mem_we); end
    tests++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_bus: got addr %h wdata %h expected 0 0", mem_addr, mem_wdata); end
    tests++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin fails++; $display("[TB] FAIL reset_acks: got if %b d %b expected 0 0", if_ack, d_ack); end
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    tests++; if (mem_en !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_reset: got en %b if_ack %b d_ack %b expected 0 0 0", mem_en, if_ack, d_ack); end
    next_cycle();
  endtask

  task automatic test_fetch_alone();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    tests++; if (mem_en !== 1'b1 || mem_addr !== 10'd4 || mem_we !== 4'b0) begin fails++; $display("[TB] FAIL fetch_issue: got en %b addr %h we %b expected 1 004 0000", mem_en, mem_addr, mem_we); end
    tests++; if (if_ack !== 1'b0) begin fails++; $display("[TB] FAIL fetch_early_ack: got %b expected 0", if_ack); end
    next_cycle();
    @(negedge clk);
    tests++; if (if_ack !== 1'b1 || if_rdata !== 32'h00500093) begin fails++; $display("[TB] FAIL fetch_ack: got ack %b rdata %h expected 1 00500093", if_ack, if_rdata); end
    tests++; if (mem_en !== 1'b0) begin fails++; $display("[TB] FAIL fetch_masked: got en %b expected 0", mem_en); end
    next_cycle();
    @(negedge clk);
    tests++; if (mem_en !== 1'b1 || if_ack !== 1'b0) begin fails++; $display("[TB] FAIL fetch_reissue: got en %b ack %b expected 1 0", mem_en, if_ack); end
    next_cycle();
    @(negedge clk);
    tests++; if (if_ack !== 1'b1 || if_rdata !== 32'h00500093) begin fails++; $display("[TB] FAIL fetch_ack2: got ack %b rdata %h expected 1 00500093", if_ack, if_rdata); end
    next_cycle();
    if_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_interleave();
    logic [9:0]  exp_addr;
    logic        exp_dack, exp_iack;
    logic [31:0] exp_drd, exp_ird;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h20; d_wdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      exp_addr = (k % 2 == 0) ? 10'd8 : 10'd4;
      exp_dack = (k % 2 == 1);
      exp_iack = (k % 2 == 0) && (k > 0);
      exp_drd  = exp_dack ? 32'h11223344 : 32'h0;
      exp_ird  = exp_iack ? 32'h00500093 : 32'h0;
      @(negedge clk);
      tests++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin fails++; $display("[TB] FAIL interleave_issue[%0d]: got en %b addr %h expected 1 %h", k, mem_en, mem_addr, exp_addr); end
      tests++; if (d_ack !== exp_dack || d_rdata !== exp_drd) begin fails++; $display("[TB] FAIL interleave_dack[%0d]: got %b %h expected %b %h", k, d_ack, d_rdata, exp_dack, exp_drd); end
      tests++; if (if_ack !== exp_iack || if_rdata !== exp_ird) begin fails++; $display("[TB] FAIL interleave_iack[%0d]: got %b %h expected %b %h", k, if_ack, if_rdata, exp_iack, exp_ird); end
      next_cycle();
    end
    d_req = 1'b0;
    @(negedge clk);
    tests++; if (if_ack !== 1'b1 || if_rdata !== 32'h00500093 || mem_en !== 1'b0) begin fails++; $display("[TB] FAIL interleave_tail: got ack %b rdata %h en %b expected 1 00500093 0", if_ack, if_rdata, mem_en); end
    next_cycle();
    if_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_byte();
    d_access(1'b1, 3'b000, 32'h23, 32'h000000AB);
    tests++; if (is_en !== 1'b1 || is_we !== 4'b1000 || is_wdata !== 32'hABABABAB || is_addr !== 10'd8) begin fails++; $display("[TB] FAIL sb_issue: got en %b we %b wdata %h addr %h expected 1 1000 abababab 008", is_en, is_we, is_wdata, is_addr); end
    tests++; if (ak_ack !== 1'b1 || ak_rdata !== 32'h0 || ak_mis !== 1'b0) begin fails++; $display("[TB] FAIL sb_ack: got %b %h %b expected 1 00000000 0", ak_ack, ak_rdata, ak_mis); end
    d_access(1'b0, 3'b000, 32'h23, 32'h0);
    tests++; if (is_we !== 4'b0 || ak_rdata !== 32'hFFFFFFAB) begin fails++; $display("[TB] FAIL lb: got we %b rdata %h expected 0000 ffffffab", is_we, ak_rdata); end
    d_access(1'b0, 3'b100, 32'h23, 32'h0);
    tests++; if (ak_ack !== 1'b1 || ak_rdata !== 32'h000000AB) begin fails++; $display("[TB] FAIL lbu: got ack %b rdata %h expected 1 000000ab", ak_ack, ak_rdata); end
    d_access(1'b0, 3'b000, 32'h21, 32'h0);
    tests++; if (ak_rdata !== 32'h00000033) begin fails++; $display("[TB] FAIL lb_lane1: got %h expected 00000033", ak_rdata); end
  endtask

  task automatic test_half();
    d_access(1'b1, 3'b001, 32'h06, 32'h00008001);
    tests++; if (is_we !== 4'b1100 || is_wdata !== 32'h80018001 || is_addr !== 10'd1) begin fails++; $display("[TB] FAIL sh_issue: got we %b wdata %h addr %h expected 1100 80018001 001", is_we, is_wdata, is_addr); end
    d_access(1'b0, 3'b001, 32'h06, 32'h0);
    tests++; if (ak_rdata !== 32'hFFFF8001) begin fails++; $display("[TB] FAIL lh: got %h expected ffff8001", ak_rdata); end
    d_access(1'b0, 3'b101, 32'h06, 32'h0);
    tests++; if (ak_rdata !== 32'h00008001) begin fails++; $display("[TB] FAIL lhu: got %h expected 00008001", ak_rdata); end
    d_access(1'b0, 3'b010, 32'h04, 32'h0);
    tests++; if (ak_rdata !== 32'h80010000) begin fails++; $display("[TB] FAIL lw_after_sh: got %h expected 80010000", ak_rdata); end
  endtask

  task automatic test_misalign();
    d_access(1'b0, 3'b010, 32'h21, 32'h0);
    tests++; if (is_en !== 1'b0 || ak_ack !== 1'b1 || ak_mis !== 1'b1 || ak_rdata !== 32'h0) begin fails++; $display("[TB] FAIL lw_misalign: got en %b ack %b mis %b rdata %h expected 0 1 1 0", is_en, ak_ack, ak_mis, ak_rdata); end
    d_access(1'b1, 3'b001, 32'h05, 32'h1234);
    tests++; if (is_en !== 1'b0 || is_we !== 4'b0 || ak_mis !== 1'b1) begin fails++; $display("[TB] FAIL sh_misalign: got en %b we %b mis %b expected 0 0000 1", is_en, is_we, ak_mis); end
    d_access(1'b0, 3'b011, 32'h20, 32'h0);
    tests++; if (is_en !== 1'b0 || ak_mis !== 1'b1 || ak_rdata !== 32'h0) begin fails++; $display("[TB] FAIL f3_011: got en %b mis %b rdata %h expected 0 1 0", is_en, ak_mis, ak_rdata); end
    d_access(1'b1, 3'b100, 32'h20, 32'h55);
    tests++; if (is_en !== 1'b0 || ak_mis !== 1'b1) begin fails++; $display("[TB] FAIL store_bu_illegal: got en %b mis %b expected 0 1", is_en, ak_mis); end
    f_access(32'h2);
    tests++; if (is_en !== 1'b0 || ak_ack !== 1'b1 || ak_mis !== 1'b1 || ak_rdata !== 32'h0) begin fails++; $display("[TB] FAIL if_misalign: got en %b ack %b mis %b rdata %h expected 0 1 1 0", is_en, ak_ack, ak_mis, ak_rdata); end
  endtask

  task automatic test_reset_mid();
    d_access(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    tests++; if (is_we !== 4'b1111 || is_wdata !== 32'hCAFEF00D || is_addr !== 10'h10) begin fails++; $display("[TB] FAIL sw_issue: got we %b wdata %h addr %h expected 1111 cafef00d 010", is_we, is_wdata, is_addr); end
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h40;
    @(negedge clk);
    tests++; if (mem_en !== 1'b1) begin fails++; $display("[TB] FAIL mid_issue: got en %b expected 1", mem_en); end
    next_cycle();
    rst = 1'b0;
    #1;
    tests++; if (d_ack !== 1'b0 || d_rdata !== 32'h0 || d_misalign !== 1'b0) begin fails++; $display("[TB] FAIL mid_ack_dropped: got %b %h %b expected 0 0 0", d_ack, d_rdata, d_misalign); end
    tests++; if (mem_en !== 1'b0 || mem_addr !== 10'h0 || if_ack !== 1'b0) begin fails++; $display("[TB] FAIL mid_outputs: got en %b addr %h if_ack %b expected 0 000 0", mem_en, mem_addr, if_ack); end
    next_cycle();
    @(negedge clk);
    tests++; if (d_ack !== 1'b0 || mem_en !== 1'b0) begin fails++; $display("[TB] FAIL mid_held: got ack %b en %b expected 0 0", d_ack, mem_en); end
    d_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    d_access(1'b0, 3'b010, 32'h40, 32'h0);
    tests++; if (ak_ack !== 1'b1 || ak_rdata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL after_reset_lw: got %b %h expected 1 cafef00d", ak_ack, ak_rdata); end
    // Write strobed just before reset must still land in memory.
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h44; d_wdata = 32'hDEADBEEF;
    next_cycle();
    rst = 1'b0;
    d_req = 1'b0;
    #1;
    tests++; if (d_ack !== 1'b0) begin fails++; $display("[TB] FAIL write_reset_ack: got %b expected 0", d_ack); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    d_access(1'b0, 3'b010, 32'h44, 32'h0);
    tests++; if (ak_rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL write_survives_reset: got %h expected deadbeef", ak_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    mem[8] = 32'h11223344;
    mem_rdata = 32'h0;
    test_reset();
    test_fetch_alone();
    test_interleave();
    test_byte();
    test_half();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, synchronous-read unified memory between the instruction-fetch (IF) port and the data (load/store) port of the pipelined RISC-V core.
- Arbitrates per cycle and acknowledges each access one cycle after issue.
- Performs byte/halfword store lane steering and byte-enable generation.
- Performs load alignment with sign/zero extension, and flags misaligned or illegal accesses.

Parameters:
- MEM_AW, 10, word-address width of the unified memory (depth 2^MEM_AW words of 32 bits).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  fetch completed this cycle.
- if_rdata  out  32  fetched instruction; valid when if_ack, else 0.
- if_misalign  out  1  with if_ack: if_addr[1:0]!=0, no memory access made.
- d_req  in  1  data request; held with all d_* inputs until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RISC-V funct3 of the load/store.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data (unaligned, low bits significant).
- d_ack  out  1  data access completed this cycle.
- d_rdata  out  32  extended load data; valid when d_ack and load, else 0.
- d_misalign  out  1  with d_ack: misaligned or illegal funct3, no memory access made.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables; 0000 = read.
- mem_addr  out  MEM_AW  word address = byte address [MEM_AW+1:2]; upper bits ignored.
- mem_wdata  out  32  lane-steered write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read strobe.

Behaviour:
- Timing: issue in cycle N (mem_* driven combinationally), ack in N+1. Writes commit at the N edge; the ack still arrives in N+1.
- Pending register holds: owner ∈ {NONE, IF, D}, addr[1:0], funct3, we, misalign. Reset value: owner=NONE.
- Eligibility: a requester is eligible in cycle N when its req=1 and it is not the owner being acked in N. Requesters update inputs only after the ack edge, so the acked request is masked.
- Priority: D over IF when both are eligible. Owner at edge = granted requester, else NONE.
- Throughput:
  - One requester alone: one access per 2 cycles.
  - Both requesters: interleaved, one access per cycle. No starvation.
- Fetch misalign: the slot is granted, mem_en=0; next cycle if_ack=1, if_misalign=1, if_rdata=0.
- Data legality:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other funct3, lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0 → misaligned. The slot is granted with mem_en=0; next cycle d_ack=1, d_misalign=1, d_rdata=0.
- Store steering:
  - sb: mem_wdata={4{wdata[7:0]}}, mem_we=0001<<addr[1:0].
  - sh: mem_wdata={2{wdata[15:0]}}, mem_we=0011<<addr[1:0].
  - sw: mem_wdata=wdata, mem_we=1111.
- Load extraction: byte lane = addr[1:0], halfword lane = addr[1]. Signed loads sign-extend; unsigned loads zero-extend.
- Idle outputs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; acks, misalign flags and rdata=0.
- Reset mid-operation: owner→NONE immediately and the pending ack is dropped. A write strobed before reset remains committed. Requesters must re-request after reset.
- Outputs during reset: all outputs are 0.

Decomposition:
- Shared package:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Owner encoding: OWN_NONE=2'b00, OWN_IF=2'b01, OWN_D=2'b10.
- Sub-module load_store_align (combinational):
  - Inputs: funct3, addr[1:0], we, wdata, rdata.
  - Outputs: byte_en, steered wdata, extended rdata, illegal/misalign flag.
- Arbiter FSM and pending register stay in unified_mem_arbiter.

Test Plan:
- IF alone, if_addr=0x10, mem word 4 = 0x00500093 → mem_en in N; if_ack=1, if_rdata=0x00500093 in N+1; re-issue in N+2.
- IF and D requesting together continuously (D lw 0x20) → D issued first; then IF, D, IF... alternate every cycle; each ack lands 1 cycle after its issue.
- sb 0x23 wdata=0x000000AB, then lb 0x23 and lbu 0x23 → mem_we=1000, mem_wdata=0xABABABAB; lb returns 0xFFFFFFAB, lbu returns 0x000000AB.
- sh 0x06 wdata=0x8001, then lh/lhu 0x06 → mem_we=1100; lh returns 0xFFFF8001, lhu returns 0x00008001.
- lw 0x21, sh 0x05, funct3=011 load, if_addr=0x2 → mem_en=0 in each slot; ack with misalign=1 and rdata=0 in the next cycle.
- Assert rst=0 in the cycle after a D read issue → no d_ack, owner=NONE, all outputs 0; after release, a fresh request completes normally.
